regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Parametrised multi-port physical register file for the out-of-order core: NREAD combinational read ports, NWRITE clocked write ports, NALLOC busy-allocation ports.
- Adds features the fixed 4-write/8-read file lacks: a per-register ready scoreboard, same-cycle write-to-read bypass, and write-collision detection.
- Sits between rename/dispatch (allocation), issue (operand read, ready check) and writeback (write ports).

Parameters:
WIDTH, 6, physical register address width; depth = 2**WIDTH.
DATA, 32, data width in bits.
NREAD, 8, number of read ports.
NWRITE, 4, number of write ports.
NALLOC, 2, number of allocation (mark-busy) ports.

Ports:
i_clk  input  1  clock, rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_raddr  input  NREAD*WIDTH  read addresses; port k uses bits [k*WIDTH +: WIDTH].
o_rdata  output  NREAD*DATA  read data; port k uses bits [k*DATA +: DATA].
o_rready  output  NREAD  ready bit for each read address.
i_we  input  NWRITE  write enables.
i_waddr  input  NWRITE*WIDTH  write addresses.
i_wdata  input  NWRITE*DATA  write data.
i_alloc  input  NALLOC  allocation enables.
i_alloc_addr  input  NALLOC*WIDTH  registers to mark busy.
o_wcollide  output  1  sticky write-collision flag.

Behaviour:
- Reset: while i_rst_n = 0 (asynchronous), all entries are 0, all ready bits are 1, and o_wcollide = 0. o_rdata therefore reads 0 and o_rready reads all-1s.
- Register 0: always reads 0 with ready = 1. Writes to address 0 and allocations of address 0 are ignored.
- Read, combinational with 0 cycles latency, evaluated per port k:
  - addr = 0: data 0, ready 1.
  - Else, if any write port j has i_we[j] = 1 and i_waddr[j] = addr: bypass i_wdata of the highest such j, with ready = 1.
  - Else: stored data and stored ready bit.
- Allocation does not affect same-cycle reads; the ready bit clears visibly from the next cycle.
- Write at posedge: for each enabled port with a nonzero address, entry <= wdata and ready bit <= 1. If several ports target the same address, the highest port index wins.
- Allocate at posedge: ready bit <= 0 for each enabled nonzero i_alloc_addr. Data is unchanged.
- Same address written and allocated in the same cycle: allocation wins the ready bit, which becomes 0. The data still takes the write value.
- Collision: two or more enabled write ports with the same nonzero address in one cycle set o_wcollide = 1 from the next posedge. It stays set until reset.
  - Address-0 duplicates do not count.
  - Duplicate allocations are legal and do not count.
- Reset asserted mid-operation: all state clears immediately, and pending writes are discarded.
- Purely synchronous storage otherwise: no read-side state and no debug file output.

Test Plan:
- Reset, then read all addresses on all ports -> data 0 and ready 1 everywhere; o_wcollide = 0.
- Write 0xDEADBEEF to r5 via port 2, then read r5 on port 7 in the same cycle -> bypass 0xDEADBEEF with ready 1. Next cycle, with no write -> stored 0xDEADBEEF.
- Write 0x1234 to r0 -> reads of r0 stay 0 with ready 1; o_wcollide stays 0.
- Allocate r9 -> r9 ready 0 the next cycle. Then write 0x55 to r9 -> bypass ready 1 in that cycle, stored ready 1 after the edge. Allocate and write r9 together -> r9 data 0x77, ready 0.
- Write ports 0 and 3 both target r12 with 0xAAAA and 0xBBBB -> same-cycle read gives 0xBBBB; stored value 0xBBBB; o_wcollide = 1 and still 1 after 10 idle cycles.
- Drive writes to r3, r4 and an allocation of r6, then pulse i_rst_n low between edges -> outputs clear immediately to reset values, and no write is retained after reset release.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// Multi-port physical register file with a per-register ready scoreboard,
// same-cycle write-to-read bypass and a sticky write-collision flag.
module regfile_mp_sb #(
  parameter int WIDTH  = 6,
  parameter int DATA   = 32,
  parameter int NREAD  = 8,
  parameter int NWRITE = 4,
  parameter int NALLOC = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NREAD*WIDTH-1:0]  i_raddr,
  output logic [NREAD*DATA-1:0]   o_rdata,
  output logic [NREAD-1:0]        o_rready,
  input  logic [NWRITE-1:0]       i_we,
  input  logic [NWRITE*WIDTH-1:0] i_waddr,
  input  logic [NWRITE*DATA-1:0]  i_wdata,
  input  logic [NALLOC-1:0]       i_alloc,
  input  logic [NALLOC*WIDTH-1:0] i_alloc_addr,
  output logic                    o_wcollide
);

  localparam int DEPTH = 1 << WIDTH;

  logic [DATA-1:0]  mem [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic             collide;

  // Two enabled write ports aiming at the same nonzero register this cycle.
  always_comb begin
    collide = 1'b0;
    for (int i = 0; i < NWRITE; i++) begin
      for (int j = i + 1; j < NWRITE; j++) begin
        if (i_we[i] && i_we[j] &&
            (i_waddr[i*WIDTH +: WIDTH] == i_waddr[j*WIDTH +: WIDTH]) &&
            (i_waddr[i*WIDTH +: WIDTH] != '0))
          collide = 1'b1;
      end
    end
  end

  // Later ports overwrite earlier ones; allocation clears after the writes so it wins the ready bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdy        <= '1;
      o_wcollide <= 1'b0;
    end else begin
      for (int j = 0; j < NWRITE; j++) begin
        if (i_we[j] && (i_waddr[j*WIDTH +: WIDTH] != '0)) begin
          mem[i_waddr[j*WIDTH +: WIDTH]] <= i_wdata[j*DATA +: DATA];
          rdy[i_waddr[j*WIDTH +: WIDTH]] <= 1'b1;
        end
      end
      for (int a = 0; a < NALLOC; a++) begin
        if (i_alloc[a] && (i_alloc_addr[a*WIDTH +: WIDTH] != '0))
          rdy[i_alloc_addr[a*WIDTH +: WIDTH]] <= 1'b0;
      end
      if (collide) o_wcollide <= 1'b1;
    end
  end

  // Bypass is suppressed while in reset so outputs show the cleared state immediately.
  always_comb begin
    o_rdata  = '0;
    o_rready = '0;
    for (int k = 0; k < NREAD; k++) begin
      o_rdata[k*DATA +: DATA] = mem[i_raddr[k*WIDTH +: WIDTH]];
      o_rready[k]             = rdy[i_raddr[k*WIDTH +: WIDTH]];
      for (int j = 0; j < NWRITE; j++) begin
        if (i_rst_n && i_we[j] &&
            (i_waddr[j*WIDTH +: WIDTH] == i_raddr[k*WIDTH +: WIDTH])) begin
          o_rdata[k*DATA +: DATA] = i_wdata[j*DATA +: DATA];
          o_rready[k]             = 1'b1;
        end
      end
      if (i_raddr[k*WIDTH +: WIDTH] == '0) begin
        o_rdata[k*DATA +: DATA] = '0;
        o_rready[k]             = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Randomised and directed bench for regfile_mp_sb against an array-based
// reference model of the register file, scoreboard and collision flag.
module tb_regfile_mp_sb;
  localparam int W  = 6;
  localparam int D  = 32;
  localparam int NR = 8;
  localparam int NW = 4;
  localparam int NA = 2;
  localparam int DEPTH = 1 << W;

  logic            i_clk;
  logic            i_rst_n;
  logic [NR*W-1:0] raddr;
  logic [NR*D-1:0] rdata;
  logic [NR-1:0]   rready;
  logic [NW-1:0]   we;
  logic [NW*W-1:0] waddr;
  logic [NW*D-1:0] wdata;
  logic [NA-1:0]   alloc;
  logic [NA*W-1:0] alloc_addr;
  logic            wcollide;

  regfile_mp_sb #(.WIDTH(W), .DATA(D), .NREAD(NR), .NWRITE(NW), .NALLOC(NA)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_raddr(raddr), .o_rdata(rdata),
    .o_rready(rready), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
    .i_alloc(alloc), .i_alloc_addr(alloc_addr), .o_wcollide(wcollide)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int checks = 0;
  int errors = 0;

  logic [D-1:0] mem_m [DEPTH];
  bit           rdy_m [DEPTH];
  bit           coll_m;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = '0;
      rdy_m[i] = 1'b1;
    end
    coll_m = 1'b0;
  endtask

  // Clock-edge effect of the currently driven inputs on the model.
  task automatic model_edge();
    for (int i = 0; i < NW; i++)
      for (int j = i + 1; j < NW; j++)
        if (we[i] && we[j] && waddr[i*W +: W] == waddr[j*W +: W] && waddr[i*W +: W] != 0)
          coll_m = 1'b1;
    for (int j = 0; j < NW; j++)
      if (we[j] && waddr[j*W +: W] != 0) begin
        mem_m[waddr[j*W +: W]] = wdata[j*D +: D];
        rdy_m[waddr[j*W +: W]] = 1'b1;
      end
    for (int a = 0; a < NA; a++)
      if (alloc[a] && alloc_addr[a*W +: W] != 0)
        rdy_m[alloc_addr[a*W +: W]] = 1'b0;
  endtask

  task automatic clr_inputs();
    raddr = '0; we = '0; waddr = '0; wdata = '0; alloc = '0; alloc_addr = '0;
  endtask

  task automatic set_rd(input int k, input int a);
    raddr[k*W +: W] = a[W-1:0];
  endtask

  task automatic set_wr(input int j, input int a, input logic [D-1:0] d);
    we[j] = 1'b1;
    waddr[j*W +: W] = a[W-1:0];
    wdata[j*D +: D] = d;
  endtask

  task automatic set_al(input int j, input int a);
    alloc[j] = 1'b1;
    alloc_addr[j*W +: W] = a[W-1:0];
  endtask

  task automatic step();
    @(posedge i_clk);
    model_edge();
    @(negedge i_clk);
  endtask

  task automatic check_reads(input string tag);
    int           a;
    logic [D-1:0] ed;
    bit           er;
    for (int k = 0; k < NR; k++) begin
      a  = int'(raddr[k*W +: W]);
      ed = mem_m[a];
      er = rdy_m[a];
      if (i_rst_n)
        for (int j = 0; j < NW; j++)
          if (we[j] && int'(waddr[j*W +: W]) == a) begin
            ed = wdata[j*D +: D];
            er = 1'b1;
          end
      if (a == 0) begin
        ed = '0;
        er = 1'b1;
      end
      checks++;
      if (rdata[k*D +: D] !== ed) begin
        errors++;
        $display("FAIL %s rdata port %0d addr %0d got %h exp %h", tag, k, a, rdata[k*D +: D], ed);
      end
      checks++;
      if (rready[k] !== er) begin
        errors++;
        $display("FAIL %s rready port %0d addr %0d got %b exp %b", tag, k, a, rready[k], er);
      end
    end
    checks++;
    if (wcollide !== coll_m) begin
      errors++;
      $display("FAIL %s wcollide got %b exp %b", tag, wcollide, coll_m);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    clr_inputs();
    model_reset();
    repeat (2) @(negedge i_clk);
    for (int r = 0; r < DEPTH / NR; r++) begin
      for (int k = 0; k < NR; k++) set_rd(k, r * NR + k);
      #1 check_reads("reset");
    end
    i_rst_n = 1'b1;
    step();
    for (int r = 0; r < DEPTH / NR; r++) begin
      for (int k = 0; k < NR; k++) set_rd(k, r * NR + k);
      #1 check_reads("post_reset");
    end
  endtask

  task automatic test_bypass();
    clr_inputs();
    set_wr(2, 5, 32'hDEADBEEF);
    set_rd(7, 5);
    #1 check_reads("bypass");
    checks++;
    if (rdata[7*D +: D] !== 32'hDEADBEEF || rready[7] !== 1'b1) begin
      errors++;
      $display("FAIL bypass_direct got %h/%b exp deadbeef/1", rdata[7*D +: D], rready[7]);
    end
    step();
    we = '0;
    #1 check_reads("bypass_stored");
    checks++;
    if (rdata[7*D +: D] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL stored_direct got %h exp deadbeef", rdata[7*D +: D]);
    end
  endtask

  task automatic test_r0();
    clr_inputs();
    set_wr(1, 0, 32'h1234);
    set_wr(3, 0, 32'h5678);
    set_al(0, 0);
    #1 check_reads("r0_same");
    step();
    clr_inputs();
    #1 check_reads("r0_after");
  endtask

  task automatic test_alloc();
    clr_inputs();
    set_al(1, 9);
    set_rd(0, 9);
    #1 check_reads("alloc_same");
    step();
    alloc = '0;
    #1 check_reads("alloc_next");
    checks++;
    if (rready[0] !== 1'b0) begin
      errors++;
      $display("FAIL alloc_busy got %b exp 0", rready[0]);
    end
    set_wr(0, 9, 32'h55);
    #1 check_reads("alloc_wr_bypass");
    step();
    clr_inputs();
    set_rd(0, 9);
    #1 check_reads("alloc_wr_stored");
    set_wr(3, 9, 32'h77);
    set_al(0, 9);
    step();
    clr_inputs();
    set_rd(4, 9);
    #1 check_reads("alloc_and_wr");
    checks++;
    if (rdata[4*D +: D] !== 32'h77 || rready[4] !== 1'b0) begin
      errors++;
      $display("FAIL alloc_wr_direct got %h/%b exp 77/0", rdata[4*D +: D], rready[4]);
    end
  endtask

  task automatic test_collide();
    clr_inputs();
    set_wr(0, 12, 32'hAAAA);
    set_wr(3, 12, 32'hBBBB);
    set_rd(0, 12);
    #1 check_reads("collide_same");
    checks++;
    if (rdata[0 +: D] !== 32'hBBBB) begin
      errors++;
      $display("FAIL collide_bypass got %h exp bbbb", rdata[0 +: D]);
    end
    step();
    clr_inputs();
    set_rd(0, 12);
    #1 check_reads("collide_next");
    repeat (10) step();
    #1 check_reads("collide_sticky");
    checks++;
    if (wcollide !== 1'b1 || rdata[0 +: D] !== 32'hBBBB) begin
      errors++;
      $display("FAIL collide_direct got %b/%h exp 1/bbbb", wcollide, rdata[0 +: D]);
    end
  endtask

  task automatic test_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      clr_inputs();
      for (int k = 0; k < NR; k++) set_rd(k, $urandom_range(15));
      for (int j = 0; j < NW; j++)
        if ($urandom_range(1)) set_wr(j, $urandom_range(15), $urandom);
      for (int a = 0; a < NA; a++)
        if ($urandom_range(2) == 0) set_al(a, $urandom_range(15));
      #1 check_reads("random");
      step();
    end
  endtask

  task automatic test_mid_reset();
    clr_inputs();
    set_wr(0, 3, 32'h3333);
    set_wr(1, 4, 32'h4444);
    set_al(0, 6);
    set_rd(0, 3); set_rd(1, 4); set_rd(2, 6);
    #1 check_reads("mid_pre");
    #1 i_rst_n = 1'b0;
    model_reset();
    #1 check_reads("mid_reset");
    checks++;
    if (wcollide !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_collide got %b exp 0", wcollide);
    end
    we = '0; alloc = '0;
    #1 i_rst_n = 1'b1;
    step();
    #1 check_reads("mid_release");
    checks++;
    if (rdata[0 +: D] !== '0 || rdata[D +: D] !== '0 || rready[2] !== 1'b1) begin
      errors++;
      $display("FAIL mid_retained got %h %h %b exp 0 0 1", rdata[0 +: D], rdata[D +: D], rready[2]);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_r0();
    test_alloc();
    test_collide();
    test_random(300);
    test_mid_reset();
    test_random(100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
